// File: rtl/rat_pkg.sv
// Shared sizing and tag types for the register alias table.
package rat_pkg;

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned AREG_W   = 5;
    localparam int unsigned PTAG_W   = 6;

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PTAG_W-1:0] ptag_t;

endpackage

// File: rtl/rat_ckpt.sv
// Shadow copy of the alias table for checkpoint save/restore.
// Built only when RAT_CHECKPOINT_EN is defined.
module rat_ckpt
    import rat_pkg::*;
#(
    parameter int unsigned NumEntries = NUM_ARCH,
    parameter int unsigned TagWidth   = PTAG_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ckptSave,
    input  logic                                  ckptRestore,
    input  logic [NumEntries-1:0][TagWidth-1:0]   tblNext,
    output logic [NumEntries-1:0][TagWidth-1:0]   shadow
);

    // Capture the post-write table on save; a simultaneous restore keeps the old shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                shadow[i] <= TagWidth'(i);
            end
        end else if (ckptSave && !ckptRestore) begin
            shadow <= tblNext;
        end
    end

endmodule

// File: rtl/rat_table.sv
// Register alias table: architectural index -> physical tag, three
// combinational read ports, one rename write port, entry 0 hardwired to 0.
// Optional checkpoint shadow enabled by defining RAT_CHECKPOINT_EN.
module rat_table #(
    parameter int unsigned NUM_ARCH = rat_pkg::NUM_ARCH,
    parameter int unsigned AREG_W   = rat_pkg::AREG_W,
    parameter int unsigned PTAG_W   = rat_pkg::PTAG_W
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RAT_CHECKPOINT_EN
    input  logic              ckpt_save,
    input  logic              ckpt_restore,
`endif
    input  logic [AREG_W-1:0] raddrRATsr1,
    output logic [PTAG_W-1:0] rdataRATsr1,
    input  logic [AREG_W-1:0] raddrRATsr2,
    output logic [PTAG_W-1:0] rdataRATsr2,
    input  logic [AREG_W-1:0] raddrRATdest,
    output logic [PTAG_W-1:0] rdataRATdest,
    input  logic              wenRATdest,
    input  logic [AREG_W-1:0] waddrRATdest,
    input  logic [PTAG_W-1:0] wdataRATdest
);

    logic [NUM_ARCH-1:0][PTAG_W-1:0] tbl;
    logic [NUM_ARCH-1:0][PTAG_W-1:0] tblNext;
    logic [NUM_ARCH-1:0][PTAG_W-1:0] tblLoad;

    // Table contents after this cycle's rename write; x0 never changes.
    always_comb begin
        tblNext = tbl;
        if (wenRATdest && (waddrRATdest != '0)) begin
            tblNext[waddrRATdest] = wdataRATdest;
        end
        tblNext[0] = '0;
    end

`ifdef RAT_CHECKPOINT_EN
    logic [NUM_ARCH-1:0][PTAG_W-1:0] shadow;

    rat_ckpt #(
        .NumEntries (NUM_ARCH),
        .TagWidth   (PTAG_W)
    ) u_ckpt (
        .clk         (clk),
        .reset       (reset),
        .ckptSave    (ckpt_save),
        .ckptRestore (ckpt_restore),
        .tblNext     (tblNext),
        .shadow      (shadow)
    );

    // Restore wins over the rename write.
    assign tblLoad = ckpt_restore ? shadow : tblNext;
`else
    assign tblLoad = tblNext;
`endif

    // Table state: identity map while reset is low, otherwise load next contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_ARCH); i++) begin
                tbl[i] <= PTAG_W'(i);
            end
        end else begin
            tbl <= tblLoad;
        end
    end

    // Unbypassed combinational reads of the registered table.
    assign rdataRATsr1  = tbl[raddrRATsr1];
    assign rdataRATsr2  = tbl[raddrRATsr2];
    assign rdataRATdest = tbl[raddrRATdest];

endmodule

// File: tb/tb_rat_table.sv
// Self-checking bench for rat_table using a reference model and a
// scoreboard queue of expected read-port values.
`timescale 1ns/1ps
module tb_rat_table;

    localparam int unsigned NA = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 6;

    logic          clk;
    logic          reset;
    logic [AW-1:0] raddrRATsr1, raddrRATsr2, raddrRATdest;
    logic [PW-1:0] rdataRATsr1, rdataRATsr2, rdataRATdest;
    logic          wenRATdest;
    logic [AW-1:0] waddrRATdest;
    logic [PW-1:0] wdataRATdest;
`ifdef RAT_CHECKPOINT_EN
    logic          ckpt_save;
    logic          ckpt_restore;
`endif

    logic [PW-1:0] model   [NA];
    logic [PW-1:0] shadowM [NA];
    logic [PW-1:0] sbq [$];
    int checks;
    int failures;

    rat_table #(.NUM_ARCH(NA), .AREG_W(AW), .PTAG_W(PW)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef RAT_CHECKPOINT_EN
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
`endif
        .raddrRATsr1  (raddrRATsr1),
        .rdataRATsr1  (rdataRATsr1),
        .raddrRATsr2  (raddrRATsr2),
        .rdataRATsr2  (rdataRATsr2),
        .raddrRATdest (raddrRATdest),
        .rdataRATdest (rdataRATdest),
        .wenRATdest   (wenRATdest),
        .waddrRATdest (waddrRATdest),
        .wdataRATdest (wdataRATdest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < int'(NA); i++) begin
            model[i]   = PW'(i);
            shadowM[i] = PW'(i);
        end
    endtask

    // Drive three read addresses, queue the model's answers, then compare.
    task automatic expectPorts(input string tag, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        raddrRATsr1  = a1;
        raddrRATsr2  = a2;
        raddrRATdest = a3;
        sbq.push_back(model[a1]);
        sbq.push_back(model[a2]);
        sbq.push_back(model[a3]);
        #1;
        checkEq({tag, "_sr1"},  rdataRATsr1,  sbq.pop_front());
        checkEq({tag, "_sr2"},  rdataRATsr2,  sbq.pop_front());
        checkEq({tag, "_dest"}, rdataRATdest, sbq.pop_front());
    endtask

    // One clock cycle with the given write/checkpoint controls; model updated at the edge.
    task automatic stepCycle(input logic w, input logic [AW-1:0] a, input logic [PW-1:0] d,
                             input logic sv, input logic rs);
        logic [PW-1:0] nxt [NA];
        wenRATdest   = w;
        waddrRATdest = a;
        wdataRATdest = d;
`ifdef RAT_CHECKPOINT_EN
        ckpt_save    = sv;
        ckpt_restore = rs;
`endif
        @(posedge clk);
        nxt = model;
        if (w && (a != '0)) nxt[a] = d;
`ifdef RAT_CHECKPOINT_EN
        if (rs) model = shadowM;
        else    model = nxt;
        if (sv && !rs) shadowM = nxt;
`else
        if (sv || rs) model = nxt;
        else          model = nxt;
`endif
        #1;
        wenRATdest = 1'b0;
`ifdef RAT_CHECKPOINT_EN
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        wenRATdest = 1'b0;
        waddrRATdest = '0;
        wdataRATdest = '0;
        raddrRATsr1 = '0;
        raddrRATsr2 = '0;
        raddrRATdest = '0;
`ifdef RAT_CHECKPOINT_EN
        ckpt_save = 1'b0;
        ckpt_restore = 1'b0;
`endif
        modelReset();

        // Reset held, then released mid-cycle: identity without any edge.
        @(posedge clk);
        #2;
        expectPorts("rst_low", 5'd0, 5'd16, 5'd31);
        reset = 1'b1;
        expectPorts("rst_rel", 5'd0, 5'd16, 5'd31);

        // Same-cycle write is not bypassed; new tag visible after the edge.
        raddrRATdest = 5'd16;
        wenRATdest   = 1'b1;
        waddrRATdest = 5'd16;
        wdataRATdest = 6'd21;
        #1;
        checkEq("nobypass_pre", rdataRATdest, model[16]);
        stepCycle(1'b1, 5'd16, 6'd21, 1'b0, 1'b0);
        expectPorts("wr16_post", 5'd16, 5'd16, 5'd16);

        // Write to x0 is ignored.
        stepCycle(1'b1, 5'd0, 6'd40, 1'b0, 1'b0);
        expectPorts("x0_ign", 5'd0, 5'd16, 5'd1);

        // All three ports on the same freshly written entry.
        stepCycle(1'b1, 5'd9, 6'd45, 1'b0, 1'b0);
        expectPorts("same9", 5'd9, 5'd9, 5'd9);

        // Hold with write disabled.
        for (int i = 0; i < 3; i++) stepCycle(1'b0, 5'd9, 6'd1, 1'b0, 1'b0);
        expectPorts("hold", 5'd9, 5'd16, 5'd3);

        // Random writes (including x0 and idle cycles) against the model.
        for (int i = 0; i < 40; i++) begin
            stepCycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NA-1)),
                      PW'($urandom_range(0, 63)), 1'b0, 1'b0);
            expectPorts("rnd", AW'($urandom_range(0, NA-1)), AW'($urandom_range(0, NA-1)),
                        AW'($urandom_range(0, NA-1)));
        end

        // Asynchronous reset mid-cycle restores identity immediately.
        stepCycle(1'b1, 5'd5, 6'd33, 1'b0, 1'b0);
        expectPorts("wr5", 5'd5, 5'd5, 5'd0);
        #2;
        reset = 1'b0;
        modelReset();
        expectPorts("async_rst", 5'd5, 5'd9, 5'd16);

        // Write while reset is low is discarded.
        wenRATdest   = 1'b1;
        waddrRATdest = 5'd7;
        wdataRATdest = 6'd50;
        @(posedge clk);
        #1;
        expectPorts("rst_wr_drop", 5'd7, 5'd7, 5'd7);

        // First edge after release accepts the pending write.
        #2;
        reset = 1'b1;
        @(posedge clk);
        model[7] = 6'd50;
        #1;
        wenRATdest = 1'b0;
        expectPorts("first_wr", 5'd7, 5'd8, 5'd0);

`ifdef RAT_CHECKPOINT_EN
        // Fresh identity state, then save / write / restore-with-write.
        #2;
        reset = 1'b0;
        modelReset();
        #2;
        reset = 1'b1;
        stepCycle(1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
        stepCycle(1'b1, 5'd7, 6'd50, 1'b0, 1'b0);
        expectPorts("ck_wr7", 5'd7, 5'd7, 5'd7);
        stepCycle(1'b1, 5'd7, 6'd60, 1'b0, 1'b1);
        expectPorts("ck_rest7", 5'd7, 5'd7, 5'd7);

        // Save includes the same-edge write.
        stepCycle(1'b1, 5'd3, 6'd44, 1'b1, 1'b0);
        stepCycle(1'b1, 5'd3, 6'd12, 1'b0, 1'b0);
        stepCycle(1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        expectPorts("ck_save_wr", 5'd3, 5'd7, 5'd0);

        // Save together with restore leaves shadow untouched.
        stepCycle(1'b1, 5'd3, 6'd13, 1'b0, 1'b0);
        stepCycle(1'b1, 5'd3, 6'd14, 1'b1, 1'b1);
        stepCycle(1'b1, 5'd3, 6'd15, 1'b0, 1'b0);
        stepCycle(1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
        expectPorts("ck_both", 5'd3, 5'd3, 5'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rat_table.md
RAT_TABLE -- requirements
Module: rat_table

Interface
REQ-001 Parameter NUM_ARCH, default 32: architectural registers mapped.
REQ-002 Parameter AREG_W, default 5: architectural index width.
REQ-003 Parameter PTAG_W, default 6: physical tag width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; table initialised while low.
REQ-006 raddrRATsr1  input  AREG_W  source-1 architectural index.
REQ-007 rdataRATsr1  output  PTAG_W  current tag for source 1.
REQ-008 raddrRATsr2  input  AREG_W  source-2 architectural index.
REQ-009 rdataRATsr2  output  PTAG_W  current tag for source 2.
REQ-010 raddrRATdest  input  AREG_W  destination index, old-mapping lookup.
REQ-011 rdataRATdest  output  PTAG_W  old tag of destination, freed at commit.
REQ-012 wenRATdest  input  1  rename-write enable.
REQ-013 waddrRATdest  input  AREG_W  architectural index being renamed.
REQ-014 wdataRATdest  input  PTAG_W  newly allocated physical tag.

Function
REQ-015 The table SHALL hold NUM_ARCH entries of PTAG_W bits.
REQ-016 All three read ports SHALL be combinational, zero latency, with no read enable.
REQ-017 Reads SHALL return the registered table contents: a write in the same cycle is not bypassed, so rdataRATdest returns the old mapping and the new tag appears the cycle after the edge.
REQ-018 When wenRATdest=1 at a rising edge, entry waddrRATdest SHALL take wdataRATdest; all other entries are unchanged.
REQ-019 Writes with waddrRATdest=0 SHALL be ignored; entry 0 permanently reads 0 (x0 hardwired).
REQ-020 Any number of read ports SHALL address the same entry simultaneously with identical results.
REQ-021 When wenRATdest=0 the table SHALL hold its value indefinitely.

Reset
REQ-022 While reset=0, entry i SHALL be forced to i (identity map, zero-extended to PTAG_W), regardless of clk.
REQ-023 After reset, all outputs SHALL equal the identity tags of their addressed indices before any clock edge.
REQ-024 A write coinciding with reset assertion SHALL be discarded.
REQ-025 Reset deassertion SHALL take effect without glitching the table; the first write is accepted at the first rising edge with reset=1.

Configuration
REQ-026 Macro RAT_CHECKPOINT_EN SHALL add input ckpt_save (1 bit), input ckpt_restore (1 bit) and one shadow copy of the table.
REQ-027 With the macro, ckpt_save at an edge SHALL copy the table, including that edge's write, into the shadow.
REQ-028 With the macro, ckpt_restore at an edge SHALL load the shadow into the table, take priority over wenRATdest, and leave the shadow unchanged when asserted together with ckpt_save.
REQ-029 With the macro, reset SHALL also initialise the shadow to identity.
REQ-030 Without the macro, no checkpoint ports or shadow SHALL exist, and behaviour SHALL be exactly REQ-015 to REQ-025.

Structure
REQ-031 Package rat_pkg SHALL hold NUM_ARCH, AREG_W, PTAG_W and typedefs areg_t and ptag_t.
REQ-032 The shadow table and its save/restore logic SHALL be sub-module rat_ckpt, instantiated only under RAT_CHECKPOINT_EN.

Verification
REQ-033 Apply and release reset; sr1=0, sr2=16, dest=31 -> rdata 0, 16, 31 with no clock edge needed.
REQ-034 Set dest read=16, wen=1, waddr=16, wdata=21 in the same cycle -> rdataRATdest=16 before the edge and 21 after it.
REQ-035 Write 0 with tag 40 -> entry 0 still reads 0; other entries unchanged.
REQ-036 Write 5 with tag 33, then assert reset mid-cycle without a clock -> entry 5 reads 5 immediately.
REQ-037 With RAT_CHECKPOINT_EN: save, write 7 with tag 50, then restore together with write 7 with tag 60 -> entry 7 reads 7.
REQ-038 All three ports read 9 after writing 9 with tag 45 -> all three return 45.
